// File: rtl/fft_frame_sequencer.sv
// Frame sequencer between the frame registers and an FFT core: double-buffers an input frame,
// streams it into the FFT one point per cycle, pulses start, then gathers N results into a held frame.
module fft_frame_sequencer #(
    parameter int  N_POINTS   = 32,
    parameter int  IN_W       = 16,
    parameter int  DATA_W     = 16,
    parameter int  COMPLEX_IN = 0,
    localparam int SAMP_W     = IN_W * ((COMPLEX_IN != 0) ? 2 : 1),
    localparam int IDX_W      = $clog2(N_POINTS),
    localparam int PT_W       = 2 * DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_POINTS*SAMP_W-1:0] in_frame,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PT_W-1:0]            fft_in,
    output logic                       fft_load,
    output logic [IDX_W-1:0]           fft_idx,
    output logic                       fft_start,
    input  logic [PT_W-1:0]            fft_out,
    input  logic                       fft_out_valid,
    output logic [N_POINTS*PT_W-1:0]   out_frame,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic                       busy
);

    typedef enum logic [2:0] {IDLE, LOAD, START, COLLECT, HOLD} state_t;

    localparam logic [IDX_W:0] LAST = (IDX_W + 1)'(N_POINTS - 1);

    state_t                     state_q, state_d;
    logic [IDX_W:0]             cnt_q, cnt_d;
    logic [N_POINTS*SAMP_W-1:0] pend_q, pend_d;
    logic                       pend_full_q, pend_full_d;
    logic [N_POINTS*SAMP_W-1:0] shift_q, shift_d;
    logic [N_POINTS*PT_W-1:0]   out_q, out_d;
    logic                       out_valid_q, out_valid_d;

    logic [SAMP_W-1:0]          head_samp;
    logic [DATA_W-1:0]          head_re, head_im;

    always_ff @(posedge clk) begin
        // NOTE: the data buffers are cleared too, so out_frame reads zero after any reset.
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            shift_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: <= makes every register sample pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            shift_q     <= shift_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first; a branch that skips one would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shift_d     = shift_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        fft_load    = 1'b0;
        fft_start   = 1'b0;

        // An empty pending buffer never coincides with leaving IDLE, so capture cannot race the copy.
        if (in_valid && !pend_full_q) begin
            pend_d      = in_frame;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_full_q && (!out_valid_q || out_ack)) begin
                    state_d     = LOAD;
                    shift_d     = pend_q;
                    pend_full_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            LOAD: begin
                fft_load = 1'b1;
                shift_d  = shift_q << SAMP_W;
                cnt_d    = cnt_q + (IDX_W + 1)'(1);
                if (cnt_q == LAST) begin
                    state_d = START;
                end
            end
            START: begin
                fft_start   = 1'b1;
                cnt_d       = '0;
                out_valid_d = 1'b0;
                state_d     = COLLECT;
            end
            COLLECT: begin
                if (fft_out_valid) begin
                    for (int i = 0; i < N_POINTS; i++) begin
                        if (cnt_q == (IDX_W + 1)'(i)) begin
                            out_d[(N_POINTS-1-i)*PT_W +: PT_W] = fft_out;
                        end
                    end
                    cnt_d = cnt_q + (IDX_W + 1)'(1);
                    if (cnt_q == LAST) begin
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    if (pend_full_q) begin
                        state_d     = LOAD;
                        shift_d     = pend_q;
                        pend_full_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Samples are left-justified into DATA_W; a real-only input gets a zero imaginary part.
    assign head_samp = shift_q[N_POINTS*SAMP_W-1 -: SAMP_W];

    always_comb begin
        head_re = '0;
        head_im = '0;
        if (COMPLEX_IN != 0) begin
            head_re[DATA_W-1 -: IN_W] = head_samp[SAMP_W-1 -: IN_W];
            head_im[DATA_W-1 -: IN_W] = head_samp[IN_W-1:0];
        end else begin
            head_re[DATA_W-1 -: IN_W] = head_samp[IN_W-1:0];
        end
    end

    assign fft_in    = (state_q == LOAD) ? {head_re, head_im} : '0;
    assign fft_idx   = (state_q == LOAD) ? cnt_q[IDX_W-1:0] : '0;
    assign in_ready  = !pend_full_q;
    assign out_frame = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: real-input instance for load/collect/double-buffer/reset,
// plus a complex-input instance for the {re,im} packing.
module tb_fft_frame_sequencer;

    localparam int N      = 8;
    localparam int IN_W   = 8;
    localparam int DATA_W = 16;
    localparam int PT_W   = 2 * DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [N*IN_W-1:0]   in_frame;
    logic                in_valid, in_ready;
    logic [PT_W-1:0]     fft_in;
    logic                fft_load;
    logic [2:0]          fft_idx;
    logic                fft_start;
    logic [PT_W-1:0]     fft_out;
    logic                fft_out_valid;
    logic [N*PT_W-1:0]   out_frame;
    logic                out_valid, out_ack, busy;

    logic [N*2*IN_W-1:0] in_frame_c;
    logic                in_valid_c, in_ready_c;
    logic [PT_W-1:0]     fft_in_c;
    logic                fft_load_c;
    logic [2:0]          fft_idx_c;
    logic                fft_start_c;
    logic [PT_W-1:0]     fft_out_c;
    logic                fft_out_valid_c;
    logic [N*PT_W-1:0]   out_frame_c;
    logic                out_valid_c, out_ack_c, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PT_W-1:0] exp_load_q[$];
    logic [PT_W-1:0] exp_out_q[$];
    logic [PT_W-1:0] exp_c_q[$];

    fft_frame_sequencer #(.N_POINTS(N), .IN_W(IN_W), .DATA_W(DATA_W), .COMPLEX_IN(0)) dut (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
        .fft_in(fft_in), .fft_load(fft_load), .fft_idx(fft_idx), .fft_start(fft_start),
        .fft_out(fft_out), .fft_out_valid(fft_out_valid), .out_frame(out_frame),
        .out_valid(out_valid), .out_ack(out_ack), .busy(busy)
    );

    fft_frame_sequencer #(.N_POINTS(N), .IN_W(IN_W), .DATA_W(DATA_W), .COMPLEX_IN(1)) dut_c (
        .clk(clk), .reset(reset), .in_frame(in_frame_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .fft_in(fft_in_c), .fft_load(fft_load_c), .fft_idx(fft_idx_c), .fft_start(fft_start_c),
        .fft_out(fft_out_c), .fft_out_valid(fft_out_valid_c), .out_frame(out_frame_c),
        .out_valid(out_valid_c), .out_ack(out_ack_c), .busy(busy_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers samples base+1..base+N; expected FFT points go to the scoreboard.
    task automatic offer_frame(input logic [7:0] base, input string tag);
        logic [N*IN_W-1:0] frame;
        logic [7:0]        s;
        for (int i = 0; i < N; i++) begin
            s = base + 8'(i + 1);
            frame[(N-1-i)*IN_W +: IN_W] = s;
            exp_load_q.push_back({s, 24'h0});
        end
        in_frame = frame;
        in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_before: in_ready=%b want 1", tag, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ready_after: in_ready=%b want 0", tag, in_ready);
        end
    endtask

    task automatic wait_load(output int waited, input string tag);
        waited = 0;
        while (fft_load !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (fft_load !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_load_timeout: fft_load=%b after %0d cycles, want 1", tag, fft_load, waited);
        end
    endtask

    task automatic check_stream(input string tag);
        logic [PT_W-1:0] exp;
        for (int i = 0; i < N; i++) begin
            exp = (exp_load_q.size() > 0) ? exp_load_q.pop_front() : 'x;
            n_checks++;
            if (fft_load !== 1'b1 || fft_idx !== 3'(i) || fft_in !== exp || fft_start !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_point%0d: load=%b idx=%0d in=%h start=%b, want load=1 idx=%0d in=%h start=0",
                         tag, i, fft_load, fft_idx, fft_in, fft_start, i, exp);
            end
            tick();
        end
        n_checks++;
        if (fft_start !== 1'b1 || fft_load !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: start=%b load=%b want start=1 load=0", tag, fft_start, fft_load);
        end
        tick();
        n_checks++;
        if (fft_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_start_pulse: start=%b busy=%b want start=0 busy=1", tag, fft_start, busy);
        end
    endtask

    // Feeds N result points (optionally with idle gaps) and checks the assembled frame.
    task automatic collect_points(input logic [31:0] base, input bit gaps, input string tag);
        logic [PT_W-1:0] e;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_early_valid%0d: out_valid=%b want 0", tag, i, out_valid);
            end
            fft_out       = base + 32'(i);
            fft_out_valid = 1'b1;
            exp_out_q.push_back(base + 32'(i));
            tick();
            fft_out_valid = 1'b0;
            fft_out       = 32'hFFFF_FFFF;
            if (gaps && i < N - 1 && (i % 2) == 0) repeat (2) tick();
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_out_valid: out_valid=%b want 1", tag, out_valid);
        end
        for (int i = 0; i < N; i++) begin
            e = (exp_out_q.size() > 0) ? exp_out_q.pop_front() : 'x;
            n_checks++;
            if (out_frame[(N-1-i)*PT_W +: PT_W] !== e) begin
                n_fail++;
                $display("FAIL %s_slot%0d: got %h want %h", tag, i, out_frame[(N-1-i)*PT_W +: PT_W], e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fft_load !== 1'b0 || busy !== 1'b0 ||
            out_frame !== '0 || fft_start !== 1'b0 || fft_in !== '0 || fft_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b oval=%b load=%b busy=%b start=%b in=%h idx=%0d frame_nz=%b, want 1,0,0,0,0,0,0,0",
                     in_ready, out_valid, fft_load, busy, fft_start, fft_in, fft_idx, |out_frame);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int waited;
        offer_frame(8'h00, "load");
        n_checks++;
        if (fft_load !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_not_yet: load=%b busy=%b want 0,0", fft_load, busy);
        end
        wait_load(waited, "load");
        n_checks++;
        if (waited != 1) begin
            n_fail++;
            $display("FAIL load_latency: %0d cycles want 1", waited);
        end
        check_stream("load");
    endtask

    task automatic test_collect();
        logic [N*PT_W-1:0] exp_frame;
        for (int i = 0; i < N; i++) exp_frame[(N-1-i)*PT_W +: PT_W] = 32'hA000_0000 + 32'(i);
        collect_points(32'hA000_0000, 1'b1, "collect");
        fft_out       = 32'h1234_5678;
        fft_out_valid = 1'b1;
        repeat (3) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_frame !== exp_frame) begin
                n_fail++;
                $display("FAIL collect_hold: out_valid=%b frame=%h want 1, %h", out_valid, out_frame, exp_frame);
            end
        end
        fft_out_valid = 1'b0;
        out_ack       = 1'b1;
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_frame !== exp_frame) begin
            n_fail++;
            $display("FAIL collect_ack: out_valid=%b busy=%b frame_kept=%b want 0,0,1",
                     out_valid, busy, out_frame === exp_frame);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        offer_frame(8'h10, "dbA");
        wait_load(waited, "dbA");
        check_stream("dbA");
        offer_frame(8'h20, "dbB");
        collect_points(32'hB000_0000, 1'b0, "dbA_out");
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (fft_load !== 1'b1 || fft_idx !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL db_direct_load: load=%b idx=%0d oval=%b ready=%b want 1,0,0,1",
                     fft_load, fft_idx, out_valid, in_ready);
        end
        check_stream("dbB");
        collect_points(32'hC000_0000, 1'b1, "dbB_out");
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL db_final_ack: oval=%b busy=%b want 0,0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int waited;
        bit stray_start;
        offer_frame(8'h30, "rst");
        wait_load(waited, "rst");
        repeat (4) tick();
        n_checks++;
        if (fft_idx !== 3'd4 || fft_load !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_at_idx4: idx=%0d load=%b want 4,1", fft_idx, fft_load);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_load_q.delete();
        n_checks++;
        if (fft_load !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_frame !== '0) begin
            n_fail++;
            $display("FAIL rst_abort: load=%b busy=%b ready=%b oval=%b frame_nz=%b want 0,0,1,0,0",
                     fft_load, busy, in_ready, out_valid, |out_frame);
        end
        stray_start   = 1'b0;
        fft_out       = 32'h5555_AAAA;
        fft_out_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) fft_out_valid = 1'b0;
            tick();
            if (fft_start !== 1'b0 || fft_load !== 1'b0) stray_start = 1'b1;
        end
        n_checks++;
        if (stray_start || out_frame !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_quiet: stray_start_or_load=%b frame_nz=%b oval=%b ready=%b want 0,0,0,1",
                     stray_start, |out_frame, out_valid, in_ready);
        end
    endtask

    task automatic test_complex();
        logic [PT_W-1:0] exp;
        int              waited;
        in_frame_c[(N-1)*16 +: 16] = {8'h7F, 8'h80};
        exp_c_q.push_back(32'h7F00_8000);
        for (int i = 1; i < N; i++) begin
            in_frame_c[(N-1-i)*16 +: 16] = {8'(i), 8'(16 + i)};
            exp_c_q.push_back({8'(i), 8'h00, 8'(16 + i), 8'h00});
        end
        in_valid_c = 1'b1;
        tick();
        in_valid_c = 1'b0;
        waited = 0;
        while (fft_load_c !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (fft_load_c !== 1'b1) begin
            n_fail++;
            $display("FAIL cplx_load_timeout: fft_load=%b want 1", fft_load_c);
        end
        fft_out_c       = 32'hDEAD_BEEF;
        fft_out_valid_c = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp = (exp_c_q.size() > 0) ? exp_c_q.pop_front() : 'x;
            n_checks++;
            if (fft_in_c !== exp || fft_idx_c !== 3'(i)) begin
                n_fail++;
                $display("FAIL cplx_point%0d: in=%h idx=%0d want %h idx=%0d", i, fft_in_c, fft_idx_c, exp, i);
            end
            tick();
        end
        fft_out_valid_c = 1'b0;
        n_checks++;
        if (fft_start_c !== 1'b1 || out_frame_c !== '0 || out_valid_c !== 1'b0) begin
            n_fail++;
            $display("FAIL cplx_ignore_out: start=%b frame_nz=%b oval=%b want 1,0,0",
                     fft_start_c, |out_frame_c, out_valid_c);
        end
    endtask

    initial begin
        reset           = 1'b0;
        in_frame        = '0;
        in_valid        = 1'b0;
        fft_out         = '0;
        fft_out_valid   = 1'b0;
        out_ack         = 1'b0;
        in_frame_c      = '0;
        in_valid_c      = 1'b0;
        fft_out_c       = '0;
        fft_out_valid_c = 1'b0;
        out_ack_c       = 1'b0;

        test_reset();
        test_load();
        test_collect();
        test_back_to_back();
        test_reset_mid_load();
        test_complex();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
